// File: rtl/md_unit.sv
// md_unit: iterative MIPS multiply/divide unit holding the HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic {IDLE, BUSY} state_e;
    localparam logic [4:0] MC = 5'(MULT_CYCLES);
    localparam logic [4:0] DC = 5'(DIV_CYCLES);
    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;
    logic [63:0] prod, result;
    // Result datapath: sign-magnitude divide keeps 0x80000000/-1 exact and avoids divide-by-zero X
    always_comb begin
        a_neg  = ~op[0] & A[31];
        b_neg  = ~op[0] & B[31];
        a_mag  = a_neg ? -A : A;
        b_mag  = b_neg ? -B : B;
        b_div  = (B == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_div;
        r_mag  = a_mag % b_div;
        quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;
        prod   = {{32{a_neg}}, A} * {{32{b_neg}}, B};
        result = op[1] ? {rem, quo} : prod;
    end
    // Next-state logic: accept requests in IDLE, count down and commit in BUSY
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start && !op[2]) begin
                res_d   = result;
                dz_d    = op[1] && (B == 32'd0);
                cnt_d   = op[1] ? DC : MC;
                state_d = BUSY;
            end else if (start && op == 3'b100) begin
                hi_d = A;
            end else if (start && op == 3'b101) begin
                lo_d = A;
            end
        end else begin
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                state_d = IDLE;
                done_d  = 1'b1;
                hi_d    = dz_q ? hi_q : res_q[63:32];
                lo_d    = dz_q ? lo_q : res_q[31:0];
            end
        end
    end
    // State registers, cleared asynchronously so a reset aborts any operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end
    assign busy = (state_q == BUSY);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit for the MIPS datapath, holding the architectural HI and LO registers. It accepts mult, multu, div, divu, mthi and mtlo from the execute stage and holds busy for a fixed latency. Its hi/lo outputs feed the writeback 32-bit 2:1 select (HI/LO path vs. ALU/memory path) that serves mfhi/mflo. The controller stalls on busy.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..31)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..31)

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low; asserting it (0) clears all state immediately
- start  input  1  request strobe, sampled on the rising clk edge
- op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 reserved (ignored)
- A  input  32  rs operand (dividend / multiplicand / mthi/mtlo source)
- B  input  32  rt operand (divisor / multiplier)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO are updated by mult/div
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- Two states: IDLE and BUSY; 5-bit down-counter cnt.
- Reset (reset=0): state IDLE, cnt=0, busy=0, done=0, hi=0, lo=0, operand/result latches cleared. Reset mid-operation aborts the operation with no HI/LO write.
- IDLE, start=1, op in {mult, multu, div, divu}: latch A, B and op, compute the result into an internal 64-bit holding register, set cnt=MULT_CYCLES or DIV_CYCLES, go to BUSY.
- IDLE, start=1, op=mthi/mtlo: write A to hi or lo at that edge. busy stays 0 and done stays 0.
- IDLE, start=1, reserved op: no effect.
- BUSY: cnt decrements each edge. On the edge where cnt==1, commit the result to hi/lo, go to IDLE and pulse done.
- start while BUSY is ignored for every op, including mthi/mtlo. The controller must stall instead.
- mult: signed 32x32 to 64-bit; hi={product[63:32]}, lo={product[31:0]}. multu: the same, unsigned.
- div: signed division; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
- Special case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- divu: unsigned division; lo=quotient, hi=remainder.
- Divisor 0 (div or divu): the full DIV_CYCLES busy period still runs, hi and lo are left unchanged, and done still pulses.
- Operands are captured at start, so A/B changing during BUSY has no effect.

## Timing
- start sampled at edge t. busy=1 from after edge t until after edge t+N, where N is the op's cycle count. busy is therefore high for exactly N cycles.
- hi/lo hold new values after edge t+N. done=1 for the single cycle following edge t+N.
- During BUSY, hi/lo continue to show the old values. mfhi/mflo must stall on busy.
- A new start may be issued in the cycle done is high, since the unit is IDLE. That start is accepted at the next edge.
- mthi/mtlo: the value is visible on hi/lo after the accepting edge. Latency 1, no busy.
- reset asserted asynchronously clears outputs without waiting for clk. After reset deasserts, the first accepting edge behaves as IDLE.

## Test plan
- Reset: hold reset=0, then release -> hi=0, lo=0, busy=0, done=0. mthi A=0x12345678 -> hi=0x12345678 one edge later, busy never 1.
- mult A=0xFFFFFFFD (-3), B=5 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulses once. multu A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7, B=2 -> lo=3, hi=1. div A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: preload hi=0xAAAA0000, lo=0x0000BBBB via mthi/mtlo, then divu B=0 -> busy 10 cycles, done pulses, hi/lo unchanged.
- Start during BUSY: issue mult 2*3, then on cycle 2 issue mtlo A=0xDEAD and div 9/3 -> both ignored; result hi=0, lo=6. A start issued in the done cycle is accepted.
- Reset mid-operation: issue div 100/7, assert reset=0 at cycle 4 -> busy, hi and lo go to 0 immediately with no done pulse. After release, a fresh mult 4*4 yields lo=16.
